fp16_signmag_normalizer: RTL and testbench



---
 rtl/fp16_signmag_normalizer.sv | 158 +++++++++++++++
 tb/tb_fp16_signmag_normalizer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fp16_signmag_normalizer.sv
// Back-end of the FP16 adder: turns the two's-complement mantissa sum into sign plus magnitude,
// then normalizes one bit per cycle while tracking the exponent, and hands off over valid/ready.
module fp16_signmag_normalizer #(
    parameter int N    = 15,
    parameter int EW   = 5,
    parameter int EMAX = 31
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_sum,
    input  logic [EW-1:0] in_exp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic [N-1:0]  out_mag,
    output logic [EW-1:0] out_exp,
    output logic          out_zero,
    output logic          out_ovf,
    output logic [1:0]    dbg_state_o
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // valid never depends on ready, and data is held stable while valid waits for ready.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0]  sum_q, sum_d;
    logic [EW-1:0] cexp_q, cexp_d;
    logic          sign_q, sign_d;
    logic [N-1:0]  mag_q, mag_d;
    logic [EW-1:0] exp_q, exp_d;
    logic          zero_q, zero_d;
    logic          ovf_q, ovf_d;

    logic          accept;
    logic          mag_is_zero;
    logic          need_rshift;
    logic          need_lshift;
    logic [EW-1:0] exp_inc;
    logic          rshift_ovf;

    assign accept      = in_valid && in_ready;
    assign mag_is_zero = (mag_q == '0);
    assign need_rshift = mag_q[N-1] | mag_q[N-2];
    assign need_lshift = !mag_q[N-3] && (exp_q > EW'(1));
    assign exp_inc     = exp_q + EW'(1);
    assign rshift_ovf  = (exp_inc == EW'(EMAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = CONV;
            CONV: state_d = NORM;
            NORM: begin
                if (mag_is_zero)      state_d = DONE;
                else if (need_rshift) state_d = rshift_ovf ? DONE : NORM;
                else if (need_lshift) state_d = NORM;
                else                  state_d = DONE;
            end
            DONE: if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = rst_n && (state_q == IDLE);
        out_valid   = (state_q == DONE);
        dbg_state_o = state_q;
    end

    // Result registers only move in CONV/NORM, so they stay frozen through DONE and IDLE.
    always_comb begin
        sum_d  = sum_q;
        cexp_d = cexp_q;
        sign_d = sign_q;
        mag_d  = mag_q;
        exp_d  = exp_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sum_d  = in_sum;
                    cexp_d = (in_exp == '0) ? EW'(1) : in_exp;
                end
            end
            CONV: begin
                sign_d = sum_q[N-1];
                mag_d  = sum_q[N-1] ? (~sum_q + N'(1)) : sum_q;
                exp_d  = cexp_q;
                zero_d = 1'b0;
                ovf_d  = 1'b0;
            end
            NORM: begin
                if (mag_is_zero) begin
                    zero_d = 1'b1;
                    sign_d = 1'b0;
                    exp_d  = '0;
                end else if (need_rshift) begin
                    // Bit 1 folds into the sticky bit so no shifted-out information is lost.
                    mag_d = {1'b0, mag_q[N-1:2], mag_q[1] | mag_q[0]};
                    exp_d = exp_inc;
                    if (rshift_ovf) ovf_d = 1'b1;
                end else if (need_lshift) begin
                    mag_d = {mag_q[N-2:0], 1'b0};
                    exp_d = exp_q - EW'(1);
                end else if (!mag_q[N-3]) begin
                    exp_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cexp_q <= '0;
            sign_q <= 1'b0;
            mag_q  <= '0;
            exp_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cexp_q <= cexp_d;
            sign_q <= sign_d;
            mag_q  <= mag_d;
            exp_q  <= exp_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_sign = sign_q;
    assign out_mag  = mag_q;
    assign out_exp  = exp_q;
    assign out_zero = zero_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_fp16_signmag_normalizer.sv
// Directed bench for fp16_signmag_normalizer: driver pushes hand-computed results into a queue,
// a negedge monitor pops and compares on every output handshake.
module tb_fp16_signmag_normalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_sum;
    logic [4:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [14:0] out_mag;
    logic [4:0]  out_exp;
    logic        out_zero;
    logic        out_ovf;
    logic [1:0]  dbg_state;

    fp16_signmag_normalizer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_mag    (out_mag),
        .out_exp    (out_exp),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf),
        .dbg_state_o(dbg_state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // packed expectation: [30] sign, [29:15] mag, [14:10] exp, [9] zero, [8] ovf, [7:0] latency
    logic [30:0] exp_q[$];
    int          acc_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [30:0] pk(input logic s, input logic [14:0] m, input logic [4:0] e,
                                       input logic z, input logic o, input logic [7:0] lat);
        return {s, m, e, z, o, lat};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // driver
    task automatic send(input logic [14:0] s, input logic [4:0] e, input logic [30:0] x,
                        input bit push);
        int w;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_sum   = s;
        in_exp   = e;
        w        = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
        end else if (push) begin
            exp_q.push_back(x);
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            w++;
            @(negedge clk);
        end
        check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    // monitor / scoreboard
    logic        prev_v = 1'b0;
    logic [22:0] snap;
    logic [30:0] x;
    int          a;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                snap = {out_sign, out_mag, out_exp, out_zero, out_ovf};
                if (exp_q.size() != 0 && exp_q[0][7:0] != 8'hFF)
                    check("latency", cyc - acc_q[0], {24'd0, exp_q[0][7:0]});
            end else if (out_valid) begin
                check("hold_stable", {out_sign, out_mag, out_exp, out_zero, out_ovf}, snap);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {31'd0, out_valid}, 32'd0);
                end else begin
                    x = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("sign", out_sign, x[30]);
                    check("mag",  out_mag,  x[29:15]);
                    check("exp",  out_exp,  x[14:10]);
                    check("zero", out_zero, x[9]);
                    check("ovf",  out_ovf,  x[8]);
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_exp    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_state",     dbg_state, 0);
        check("rst_outputs", {out_sign, out_mag, out_exp, out_zero, out_ovf}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        send(15'h1000, 5'd15, pk(1'b0, 15'h1000, 5'd15, 1'b0, 1'b0, 8'd3), 1'b1);
        send(15'h7000, 5'd15, pk(1'b1, 15'h1000, 5'd15, 1'b0, 1'b0, 8'd3), 1'b1);
        send(15'h0040, 5'd15, pk(1'b0, 15'h1000, 5'd9,  1'b0, 1'b0, 8'd9), 1'b1);
        send(15'h0040, 5'd3,  pk(1'b0, 15'h0100, 5'd0,  1'b0, 1'b0, 8'd5), 1'b1);
        send(15'h0000, 5'd15, pk(1'b0, 15'h0000, 5'd0,  1'b1, 1'b0, 8'd3), 1'b1);
        send(15'h2003, 5'd15, pk(1'b0, 15'h1001, 5'd16, 1'b0, 1'b0, 8'd4), 1'b1);
        send(15'h2003, 5'd30, pk(1'b0, 15'h1001, 5'd31, 1'b0, 1'b1, 8'hFF), 1'b1);
        send(15'h4000, 5'd15, pk(1'b1, 15'h1000, 5'd17, 1'b0, 1'b0, 8'd5), 1'b1);
        send(15'h1000, 5'd0,  pk(1'b0, 15'h1000, 5'd1,  1'b0, 1'b0, 8'd3), 1'b1);
        send(15'h0800, 5'd1,  pk(1'b0, 15'h0800, 5'd0,  1'b0, 1'b0, 8'd3), 1'b1);
        send(15'h7F80, 5'd10, pk(1'b1, 15'h1000, 5'd5,  1'b0, 1'b0, 8'd8), 1'b1);
        wait_drain();

        // backpressure in DONE with a competing input offer
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(15'h1000, 5'd20, pk(1'b0, 15'h1000, 5'd20, 1'b0, 1'b0, 8'd3), 1'b1);
        for (int w = 0; w < 50 && !out_valid; w++) @(negedge clk);
        check("hold_reached_done", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_sum   = 15'h0000;
            in_exp   = 5'd7;
            @(negedge clk);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        repeat (6) @(negedge clk);
        check("idle_after_hold", in_ready, 1);

        // reset while normalizing
        send(15'h0040, 5'd15, '0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("mid_state_norm", dbg_state, 2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_state", dbg_state, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_outputs", {out_sign, out_mag, out_exp, out_zero, out_ovf}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("midrst_recover_ready", in_ready, 1);

        send(15'h7000, 5'd12, pk(1'b1, 15'h1000, 5'd12, 1'b0, 1'b0, 8'd3), 1'b1);
        wait_drain();
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
